// File: rtl/lead_one_restorer.sv
// Rebuilds a WIDTH-bit magnitude from a leading-one code (index+1, 0 = none) and the fraction below it.
// Three register stages; all stages shift together and stall while the output is held (io_in_ready = !io_out_valid || io_out_ready).
module lead_one_restorer #(
  parameter int WIDTH = 112,
  parameter int POS_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [POS_W-1:0] io_in_pos,
  input  logic [WIDTH-2:0] io_in_frac,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_data,
  output logic             io_out_err
);

  logic             w_advance;
  logic [WIDTH-1:0] w_m;
  logic [POS_W-1:0] w_s;
  logic             w_err;
  logic             w_zero;
  logic [WIDTH-1:0] w_s1_dat;
  logic [WIDTH-1:0] w_s2_dat;
  logic [WIDTH-1:0] w_s3_dat;

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_dat;
  logic [POS_W-1:2] r_s1_s;
  logic             r_s1_zero;
  logic             r_s1_err;

  logic             r_s2_vld;
  logic [WIDTH-1:0] r_s2_dat;
  logic [POS_W-1:4] r_s2_s;
  logic             r_s2_zero;
  logic             r_s2_err;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;
  logic             r_out_err;

  assign w_advance   = !r_out_vld || io_out_ready;
  assign io_in_ready = w_advance;

  // Shift distance is WIDTH - pos; out-of-range codes wrap here and are zeroed in the last stage.
  assign w_m    = {1'b1, io_in_frac};
  assign w_s    = POS_W'(WIDTH) - io_in_pos;
  assign w_err  = io_in_pos > POS_W'(WIDTH);
  assign w_zero = (io_in_pos == '0) || w_err;

  assign w_s1_dat = w_m >> w_s[1:0];
  assign w_s2_dat = r_s1_dat >> {r_s1_s[3:2], 2'b00};
  assign w_s3_dat = r_s2_zero ? '0 : (r_s2_dat >> {r_s2_s, 4'b0000});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_err <= 1'b0;
    end else if (w_advance) begin
      r_s1_vld  <= io_in_valid;
      r_s2_vld  <= r_s1_vld;
      r_out_vld <= r_s2_vld;
      r_out_dat <= w_s3_dat;
      r_out_err <= r_s2_err;
    end
  end

  // Datapath stage registers carry no reset; their contents only matter behind a set valid.
  always_ff @(posedge clock) begin
    if (w_advance) begin
      r_s1_dat  <= w_s1_dat;
      r_s1_s    <= w_s[POS_W-1:2];
      r_s1_zero <= w_zero;
      r_s1_err  <= w_err;
      r_s2_dat  <= w_s2_dat;
      r_s2_s    <= r_s1_s[POS_W-1:4];
      r_s2_zero <= r_s1_zero;
      r_s2_err  <= r_s1_err;
    end
  end

  assign io_out_valid = r_out_vld;
  assign io_out_data  = r_out_dat;
  assign io_out_err   = r_out_err;

endmodule

// File: tb/tb_lead_one_restorer.sv
// Bench for lead_one_restorer: directed vectors, stall and reset sequences, randomized scoreboard run.
module tb_lead_one_restorer;
  localparam int W  = 112;
  localparam int PW = 7;
  localparam int NRAND = 10000;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [PW-1:0] io_in_pos;
  logic [W-2:0]  io_in_frac;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_out_data;
  logic          io_out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  lead_one_restorer #(.WIDTH(W), .POS_W(PW)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_pos   (io_in_pos),
    .io_in_frac  (io_in_frac),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_data (io_out_data),
    .io_out_err  (io_out_err)
  );

  typedef struct {
    logic [PW-1:0] pos;
    logic [W-2:0]  frac;
    logic [W-1:0]  data;
    logic          err;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Leading one sits at bit pos-1, fraction bits follow below it MSB-first, the rest fall off.
  function automatic logic [W-1:0] ref_restore(input int pos, input logic [W-2:0] frac);
    logic [W-1:0] r;
    r = '0;
    if (pos >= 1 && pos <= W) begin
      r[pos-1] = 1'b1;
      for (int i = 0; i < pos - 1; i++) r[pos-2-i] = frac[W-2-i];
    end
    return r;
  endfunction

  function automatic int lod(input logic [W-1:0] d);
    int p;
    p = 0;
    for (int i = 0; i < W; i++) if (d[i]) p = i + 1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single beat into an idle pipe with out_ready high: visible after the 3rd register edge.
  task automatic apply_one(input string name, input logic [PW-1:0] pos, input logic [W-2:0] frac,
                           input logic [W-1:0] exp_d, input logic exp_e);
    io_in_valid = 1'b1;
    io_in_pos   = pos;
    io_in_frac  = frac;
    tick();
    io_in_valid = 1'b0;
    chk1({name, " valid@N"}, io_out_valid, 1'b0);
    tick();
    chk1({name, " valid@N+1"}, io_out_valid, 1'b0);
    tick();
    chk1({name, " valid@N+2"}, io_out_valid, 1'b1);
    chk({name, " data"}, io_out_data, exp_d);
    chk1({name, " err"}, io_out_err, exp_e);
    tick();
    chk1({name, " drained"}, io_out_valid, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] plist[5];
    logic [W-1:0]  q_data[$];
    logic          q_err[$];
    int            q_pos[$];
    logic [W-1:0]  got_data[$];
    logic [W-1:0]  prev_data;
    logic          prev_stall;
    logic          acc;
    int            idx;
    int            stale;
    int            sent;
    int            got;
    logic [127:0]  t;
    logic [W-1:0]  ed;
    logic          ee;
    int            ep;
    int            r;

    tv[0] = '{pos: 7'd112, frac: '0,               data: {1'b1, 111'b0}, err: 1'b0};
    tv[1] = '{pos: 7'd1,   frac: {111{1'b1}},      data: 112'd1,         err: 1'b0};
    tv[2] = '{pos: 7'd3,   frac: {1'b1, 110'b0},   data: 112'd6,         err: 1'b0};
    tv[3] = '{pos: 7'd0,   frac: {111{1'b1}},      data: '0,             err: 1'b0};
    tv[4] = '{pos: 7'd113, frac: {111{1'b1}},      data: '0,             err: 1'b1};
    tv[5] = '{pos: 7'd127, frac: '0,               data: '0,             err: 1'b1};
    tv[6] = '{pos: 7'd4,   frac: {3'b101, 108'b1}, data: 112'hD,         err: 1'b0};

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_pos    = '0;
    io_in_frac   = '0;
    io_out_ready = 1'b1;
    tick();
    tick();
    chk1("reset out_valid", io_out_valid, 1'b0);
    chk("reset out_data", io_out_data, '0);
    chk1("reset out_err", io_out_err, 1'b0);
    reset = 1'b0;
    tick();
    chk1("idle in_ready", io_in_ready, 1'b1);

    for (int i = 0; i < 7; i++)
      apply_one($sformatf("vec%0d", i), tv[i].pos, tv[i].frac, tv[i].data, tv[i].err);

    // Stall: five back-to-back beats, out_ready low in cycles 4..6.
    plist[0] = 7'd112; plist[1] = 7'd100; plist[2] = 7'd50; plist[3] = 7'd2; plist[4] = 7'd1;
    idx = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    got_data.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      io_out_ready = !(cyc >= 4 && cyc <= 6);
      io_in_valid  = idx < 5;
      io_in_pos    = (idx < 5) ? plist[idx] : '0;
      io_in_frac   = {1'b1, 110'b0};
      @(negedge clock);
      chk1($sformatf("stall in_ready c%0d", cyc), io_in_ready, !(io_out_valid && !io_out_ready));
      if (prev_stall) begin
        chk1($sformatf("stall hold valid c%0d", cyc), io_out_valid, 1'b1);
        chk($sformatf("stall hold data c%0d", cyc), io_out_data, prev_data);
      end
      prev_stall = io_out_valid && !io_out_ready;
      prev_data  = io_out_data;
      acc = io_in_valid && io_in_ready;
      if (io_out_valid && io_out_ready) got_data.push_back(io_out_data);
      tick();
      if (acc) idx++;
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    chk("stall count", W'(got_data.size()), W'(5));
    for (int i = 0; i < 5 && i < got_data.size(); i++)
      chk($sformatf("stall order %0d", i), got_data[i], ref_restore(int'(plist[i]), {1'b1, 110'b0}));

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      io_in_valid = 1'b1;
      io_in_pos   = PW'(10 + k);
      io_in_frac  = '0;
      tick();
    end
    io_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk1("midreset out_valid", io_out_valid, 1'b0);
    chk("midreset out_data", io_out_data, '0);
    reset = 1'b0;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (io_out_valid) stale++;
    end
    chk("midreset stale beats", W'(stale), '0);
    apply_one("post-reset", 7'd5, '0, 112'h10, 1'b0);

    // Randomized run with back-pressure against the reference model.
    sent = 0;
    got  = 0;
    q_data.delete(); q_err.delete(); q_pos.delete();
    io_in_valid = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < NRAND; cyc++) begin
      @(negedge clock);
      acc = io_in_valid && io_in_ready;
      if (acc) begin
        q_data.push_back(ref_restore(int'(io_in_pos), io_in_frac));
        q_err.push_back(io_in_pos > PW'(W));
        q_pos.push_back(int'(io_in_pos));
        sent++;
      end
      if (io_out_valid && io_out_ready) begin
        if (q_data.size() == 0) begin
          chk1("rand unexpected output", 1'b1, 1'b0);
        end else begin
          ed = q_data.pop_front();
          ee = q_err.pop_front();
          ep = q_pos.pop_front();
          chk($sformatf("rand data #%0d", got), io_out_data, ed);
          chk1($sformatf("rand err #%0d", got), io_out_err, ee);
          if (ep >= 1 && ep <= W)
            chk($sformatf("rand lod #%0d", got), W'(lod(io_out_data)), W'(ep));
        end
        got++;
      end
      tick();
      if (acc || !io_in_valid) begin
        io_in_valid = (sent + (acc ? 0 : 0) < NRAND) && ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 99);
        if (r == 0)      io_in_pos = '0;
        else if (r < 3)  io_in_pos = PW'($urandom_range(113, 127));
        else             io_in_pos = PW'($urandom_range(1, 112));
        t = {$urandom, $urandom, $urandom, $urandom};
        io_in_frac = t[W-2:0];
      end
      io_out_ready = $urandom_range(0, 3) != 0;
    end
    chk("rand beats received", W'(got), W'(NRAND));
    chk("rand scoreboard empty", W'(q_data.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
